wb_bus_arbiter: RTL and testbench
=================================

Name: wb_bus_arbiter

Overview:
- Shares one 16-bit Wishbone master port between two requesters: m0 = instruction cache line fill, m1 = data-side memory unit.
- Sits between the cache/memory units and the external memory bus.
- Grant is held for the whole owner cycle (wb_cyc high), so icache 8-beat line bursts are never split.
- Round-robin fairness, plus a watchdog that aborts a hung cycle with an error to the owner.

Parameters:
- RW, 16, data/address width.
- TMO_W, 8, watchdog counter width; timeout after 2^TMO_W-1 cycles without ack.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- m0_cyc, m0_stb, m0_we  in  1 each  requester 0 Wishbone controls.
- m0_adr, m0_dat_o  in  RW each  requester 0 address and write data.
- m0_sel  in  2  requester 0 byte selects.
- m0_ack, m0_err  out  1 each  requester 0 responses.
- m0_dat_i  out  RW  requester 0 read data.
- m1_*  (same set as m0_*)  requester 1.
- wb_cyc, wb_stb, wb_we  out  1 each  shared bus controls.
- wb_adr, wb_o_dat  out  RW each  shared bus address and write data.
- wb_sel  out  2  shared bus byte selects.
- wb_i_dat  in  RW  shared bus read data.
- wb_ack  in  1  shared bus acknowledge.
- owner  out  2  debug: 00 = none, 01 = m0, 10 = m1.

Behaviour:
- States: IDLE, G0, G1. Reset state IDLE. last = 1 on reset, so m0 wins the first tie.
- IDLE:
  - m0_cyc only → G0.
  - m1_cyc only → G1.
  - Both: grant to the requester ≠ last.
  - Transition happens on the clock edge. Arbitration latency: 1 cycle from a requester's cyc to wb_cyc.
- G0/G1, bus muxing:
  - wb_cyc/stb/we/adr/sel/o_dat driven combinationally from the owner's inputs.
  - Non-owner sees ack = 0 and err = 0.
  - m*_dat_i = wb_i_dat for both requesters (no gating needed).
  - Owner ack = wb_ack & owner stb.
- Release:
  - Owner drops cyc: on that edge, move to IDLE and set last = owner.
  - If the other requester has cyc high in that same cycle, move directly to its grant state (no idle bubble). wb_cyc is low for exactly that one cycle, because the owner's cyc is already low.
- Watchdog:
  - Counter cleared on entering a grant state and on every wb_ack. Increments each cycle while wb_cyc & wb_stb & ~wb_ack.
  - At the all-ones value: pulse owner err for 1 cycle, force wb_cyc = wb_stb = 0 that cycle and afterwards, enter state ABORT.
  - ABORT holds the bus idle until the owner's cyc drops, then IDLE with last = aborted owner.
  - A wb_ack arriving in the timeout cycle wins: no err, counter clears.
- Reset values:
  - wb_cyc = wb_stb = wb_we = 0; wb_adr = wb_o_dat = 0; wb_sel = 0.
  - All m*_ack = m*_err = 0; owner = 00.
  - In IDLE, bus outputs are forced 0, not muxed.
- Reset mid-burst: asynchronous return to IDLE; bus controls drop immediately (same delta as reset assertion); counter cleared.
- A requester dropping stb while keeping cyc (wait states) retains the grant.
- A requester must not drop cyc before the last ack. The arbiter does not check this.

Test Plan:
- Single m0 8-beat burst, wb_ack every cycle after wb_stb → wb_cyc rises 1 cycle after m0_cyc; m0_ack pulses 8 times; m1_ack stays 0; owner = 01 throughout.
- m0 and m1 assert cyc in the same cycle after reset → m0 granted first (last = 1). After m0 drops cyc, G1 entered on the same edge; wb_cyc low for exactly 1 cycle; owner = 10.
- m1 holds back-to-back requests while m0 re-requests → grants alternate m0, m1, m0, m1 over 4 transactions; no starvation.
- m1 request while m0 is mid-burst at beat 3 → wb_adr keeps m0 addresses for beats 3..7; m1 granted only after m0_cyc falls.
- TMO_W = 4, slave never acks m1 → m1_err pulses once at cycle 15 of stb; wb_cyc drops; bus stays idle until m1_cyc falls; then a pending m0 is granted.
- i_rst_n pulsed low at beat 5 of an m0 burst → wb_cyc/wb_stb go 0 without a clock edge; owner = 00; first grant after release goes to m0.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// wb_bus_arbiter
// Shares one Wishbone master port between two requesters:
//   m0 = instruction cache line fill, m1 = data-side memory unit.
// The grant is held for the owner's whole cycle (cyc high), so line bursts are
// never split. Ties are resolved round-robin. A watchdog aborts a hung cycle
// with a one-cycle err pulse to the owner.
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   m0_* / m1_*              requester Wishbone ports (cyc, stb, we, adr,
//                            dat_o, sel in; ack, err, dat_i out)
//   wb_cyc, wb_stb, wb_we,
//   wb_adr, wb_o_dat, wb_sel shared bus controls (muxed from the owner)
//   wb_i_dat, wb_ack         shared bus read data and acknowledge
//   owner                    debug: 00 none, 01 m0, 10 m1
// -----------------------------------------------------------------------------
module wb_bus_arbiter #(
  parameter int RW    = 16,
  parameter int TMO_W = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [RW-1:0] m0_adr,
  input  logic [RW-1:0] m0_dat_o,
  input  logic [1:0]    m0_sel,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [RW-1:0] m0_dat_i,
  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [RW-1:0] m1_adr,
  input  logic [RW-1:0] m1_dat_o,
  input  logic [1:0]    m1_sel,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [RW-1:0] m1_dat_i,
  output logic          wb_cyc,
  output logic          wb_stb,
  output logic          wb_we,
  output logic [RW-1:0] wb_adr,
  output logic [RW-1:0] wb_o_dat,
  output logic [1:0]    wb_sel,
  input  logic [RW-1:0] wb_i_dat,
  input  logic          wb_ack,
  output logic [1:0]    owner
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_G0    = 2'b01,
    ST_G1    = 2'b10,
    ST_ABORT = 2'b11
  } state_t;

  // The counter holds the number of completed waiting cycles; the timeout
  // fires in the cycle that would bring it to all-ones.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [TMO_W-1:0] TMO_ZERO = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_nxt_s;
  logic             last_r, last_nxt_s;         // 0 = m0 owned last, 1 = m1
  logic             abort_m1_r, abort_m1_nxt_s; // which requester was aborted
  logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_nxt_s;

  logic             own_cyc_s, own_stb_s, own_we_s;
  logic [RW-1:0]    own_adr_s, own_dat_s;
  logic [1:0]       own_sel_s;
  logic             other_cyc_s;
  logic             tmo_hit_s;

  // Owner mux: selects the granted requester's bus signals, zero otherwise.
  always_comb begin
    own_cyc_s   = 1'b0;
    own_stb_s   = 1'b0;
    own_we_s    = 1'b0;
    own_adr_s   = {RW{1'b0}};
    own_dat_s   = {RW{1'b0}};
    own_sel_s   = 2'b00;
    other_cyc_s = 1'b0;
    case (state_r)
      ST_G0: begin
        own_cyc_s   = m0_cyc;
        own_stb_s   = m0_stb;
        own_we_s    = m0_we;
        own_adr_s   = m0_adr;
        own_dat_s   = m0_dat_o;
        own_sel_s   = m0_sel;
        other_cyc_s = m1_cyc;
      end
      ST_G1: begin
        own_cyc_s   = m1_cyc;
        own_stb_s   = m1_stb;
        own_we_s    = m1_we;
        own_adr_s   = m1_adr;
        own_dat_s   = m1_dat_o;
        own_sel_s   = m1_sel;
        other_cyc_s = m0_cyc;
      end
      default: begin
        own_cyc_s   = 1'b0;
        own_stb_s   = 1'b0;
      end
    endcase
  end

  // A same-cycle ack beats the timeout.
  assign tmo_hit_s = own_cyc_s & own_stb_s & ~wb_ack & (tmo_cnt_r == TMO_LAST);

  // Timeout cycle already presents an idle bus.
  assign wb_cyc   = own_cyc_s & ~tmo_hit_s;
  assign wb_stb   = own_stb_s & ~tmo_hit_s;
  assign wb_we    = own_we_s;
  assign wb_adr   = own_adr_s;
  assign wb_o_dat = own_dat_s;
  assign wb_sel   = own_sel_s;

  assign m0_ack   = (state_r == ST_G0) & wb_ack & m0_stb;
  assign m1_ack   = (state_r == ST_G1) & wb_ack & m1_stb;
  assign m0_err   = (state_r == ST_G0) & tmo_hit_s;
  assign m1_err   = (state_r == ST_G1) & tmo_hit_s;
  assign m0_dat_i = wb_i_dat;
  assign m1_dat_i = wb_i_dat;
  assign owner    = ((state_r == ST_G0) || (state_r == ST_G1)) ? state_r : 2'b00;

  // Next-state, round-robin and watchdog logic.
  always_comb begin
    state_nxt_s    = state_r;
    last_nxt_s     = last_r;
    abort_m1_nxt_s = abort_m1_r;
    tmo_cnt_nxt_s  = tmo_cnt_r;
    case (state_r)
      ST_IDLE: begin
        tmo_cnt_nxt_s = TMO_ZERO;
        if (m0_cyc && m1_cyc) begin
          state_nxt_s = last_r ? ST_G0 : ST_G1;
        end else if (m0_cyc) begin
          state_nxt_s = ST_G0;
        end else if (m1_cyc) begin
          state_nxt_s = ST_G1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_G0, ST_G1: begin
        if (tmo_hit_s) begin
          state_nxt_s    = ST_ABORT;
          abort_m1_nxt_s = (state_r == ST_G1);
          tmo_cnt_nxt_s  = TMO_ZERO;
        end else if (!own_cyc_s) begin
          // Release; hand straight over if the other side is waiting.
          last_nxt_s    = (state_r == ST_G1);
          tmo_cnt_nxt_s = TMO_ZERO;
          if (other_cyc_s) begin
            state_nxt_s = (state_r == ST_G1) ? ST_G0 : ST_G1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (wb_ack) begin
          tmo_cnt_nxt_s = TMO_ZERO;
        end else if (own_stb_s) begin
          tmo_cnt_nxt_s = tmo_cnt_r + TMO_ONE;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r;
        end
      end
      ST_ABORT: begin
        tmo_cnt_nxt_s = TMO_ZERO;
        if (abort_m1_r ? !m1_cyc : !m0_cyc) begin
          state_nxt_s = ST_IDLE;
          last_nxt_s  = abort_m1_r;
        end else begin
          state_nxt_s = ST_ABORT;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        tmo_cnt_nxt_s = TMO_ZERO;
      end
    endcase
  end

  // State, round-robin pointer and watchdog registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      last_r     <= 1'b1;
      abort_m1_r <= 1'b0;
      tmo_cnt_r  <= TMO_ZERO;
    end else begin
      state_r    <= state_nxt_s;
      last_r     <= last_nxt_s;
      abort_m1_r <= abort_m1_nxt_s;
      tmo_cnt_r  <= tmo_cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_bus_arbiter
// Directed scenarios followed by randomized traffic, every cycle compared with
// a transaction-level reference model (who owns the bus, who went last, how
// long the owner has waited without ack).
// -----------------------------------------------------------------------------
module tb_wb_bus_arbiter;
  localparam int RW      = 16;
  localparam int TMO_W   = 4;
  localparam int TMO_LIM = (1 << TMO_W) - 1;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [RW-1:0] m0_adr, m0_dat_o, m1_adr, m1_dat_o;
  logic [1:0]    m0_sel, m1_sel;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic [RW-1:0] m0_dat_i, m1_dat_i;
  logic          wb_cyc, wb_stb, wb_we, wb_ack;
  logic [RW-1:0] wb_adr, wb_o_dat, wb_i_dat;
  logic [1:0]    wb_sel, owner;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ack0  = 0;
  int n_err1  = 0;

  // Reference model: -1 = nobody, else index of the requester holding the bus.
  int mdl_own   = -1;
  bit mdl_abort = 1'b0;
  int mdl_last  = 1;
  int mdl_wait  = 0;

  always #5 i_clk = ~i_clk;

  wb_bus_arbiter #(.RW(RW), .TMO_W(TMO_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_o(m0_dat_o), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_err(m0_err),
    .m0_dat_i(m0_dat_i),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_o(m1_dat_o), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_err(m1_err),
    .m1_dat_i(m1_dat_i),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_o_dat(wb_o_dat), .wb_sel(wb_sel), .wb_i_dat(wb_i_dat),
    .wb_ack(wb_ack), .owner(owner)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input bit c0, input bit s0, input bit c1, input bit s1, input bit ack);
    m0_cyc = c0; m0_stb = s0; m1_cyc = c1; m1_stb = s1; wb_ack = ack;
    m0_we = 1'($urandom); m0_adr = RW'($urandom); m0_dat_o = RW'($urandom); m0_sel = 2'($urandom);
    m1_we = 1'($urandom); m1_adr = RW'($urandom); m1_dat_o = RW'($urandom); m1_sel = 2'($urandom);
    wb_i_dat = RW'($urandom);
  endtask

  // Compare the DUT against the model for the current inputs, then advance
  // the model by one clock edge.
  task automatic eval_cycle();
    bit            granted, oc, os, ow, hit, other_c;
    logic [RW-1:0] oa, od;
    logic [1:0]    osel;
    logic [10:0]   exp_ctl;
    bit            e_a0, e_a1, e_r0, e_r1;
    logic [1:0]    e_own;
    granted = (mdl_own >= 0) && !mdl_abort;
    oc = 0; os = 0; ow = 0; oa = '0; od = '0; osel = 2'b00; other_c = 0;
    if (mdl_own == 0) begin
      oc = m0_cyc; os = m0_stb; ow = m0_we; oa = m0_adr; od = m0_dat_o; osel = m0_sel; other_c = m1_cyc;
    end else if (mdl_own == 1) begin
      oc = m1_cyc; os = m1_stb; ow = m1_we; oa = m1_adr; od = m1_dat_o; osel = m1_sel; other_c = m0_cyc;
    end
    if (!granted) begin
      oc = 0; os = 0; ow = 0; oa = '0; od = '0; osel = 2'b00;
    end
    hit   = granted && oc && os && !wb_ack && (mdl_wait + 1 == TMO_LIM);
    e_a0  = granted && mdl_own == 0 && wb_ack && os;
    e_a1  = granted && mdl_own == 1 && wb_ack && os;
    e_r0  = hit && mdl_own == 0;
    e_r1  = hit && mdl_own == 1;
    e_own = !granted ? 2'b00 : (mdl_own == 0 ? 2'b01 : 2'b10);
    exp_ctl = {oc && !hit, os && !hit, ow, osel, e_a0, e_r0, e_a1, e_r1, e_own};
    check("ctl", {wb_cyc, wb_stb, wb_we, wb_sel, m0_ack, m0_err, m1_ack, m1_err, owner}, exp_ctl);
    check("adr", wb_adr, oa);
    check("wdat", wb_o_dat, od);
    check("rdat", {m0_dat_i, m1_dat_i}, {wb_i_dat, wb_i_dat});
    if (m0_ack) n_ack0++;
    if (m1_err) n_err1++;
    if (mdl_abort) begin
      if (!((mdl_own == 0) ? m0_cyc : m1_cyc)) begin
        mdl_last = mdl_own; mdl_own = -1; mdl_abort = 0;
      end
    end else if (mdl_own < 0) begin
      if (m0_cyc && m1_cyc) mdl_own = (mdl_last == 1) ? 0 : 1;
      else if (m0_cyc) mdl_own = 0;
      else if (m1_cyc) mdl_own = 1;
      mdl_wait = 0;
    end else if (hit) begin
      mdl_abort = 1;
    end else if (!oc) begin
      mdl_last = mdl_own;
      mdl_own  = other_c ? 1 - mdl_own : -1;
      mdl_wait = 0;
    end else if (wb_ack) begin
      mdl_wait = 0;
    end else if (os) begin
      mdl_wait++;
    end
  endtask

  task automatic run_cycle(input bit c0, input bit s0, input bit c1, input bit s1, input bit ack);
    @(negedge i_clk);
    drive(c0, s0, c1, s1, ack);
    #1;
    eval_cycle();
  endtask

  initial begin
    int a0, e1, ack_pct;
    bit c0, c1;
    i_rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    @(negedge i_clk);
    @(negedge i_clk);
    m0_cyc = 1'b1; m1_cyc = 1'b1; m0_stb = 1'b1; m1_stb = 1'b1;
    #1;
    check("rst_ctl", {wb_cyc, wb_stb, wb_we, wb_sel, m0_ack, m0_err, m1_ack, m1_err, owner}, 11'd0);
    check("rst_bus", {wb_adr, wb_o_dat}, 32'd0);
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Simultaneous request: m0 first, 8-beat burst, then m1 with one idle cycle.
    run_cycle(1, 1, 1, 1, 1);
    a0 = n_ack0;
    for (int i = 0; i < 8; i++) run_cycle(1, 1, 1, 1, 1);
    run_cycle(0, 0, 1, 1, 1);
    check("burst_acks", n_ack0 - a0, 8);
    run_cycle(0, 0, 1, 1, 1);
    check("handover_owner", owner, 2'b10);

    // m1 never acked: one err pulse, bus idle until m1 lets go, then m0.
    e1 = n_err1;
    for (int i = 0; i < 20; i++) run_cycle(0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) run_cycle(1, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) run_cycle(1, 1, 0, 0, 0);
    check("tmo_err_pulses", n_err1 - e1, 1);
    check("after_abort_owner", owner, 2'b01);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 5; i++) run_cycle(1, 1, 0, 0, 1);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("rst_async", {wb_cyc, wb_stb, owner}, 4'd0);
    drive(0, 0, 0, 0, 0);
    mdl_own = -1; mdl_abort = 0; mdl_last = 1; mdl_wait = 0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_cycle(1, 1, 1, 1, 0);
    run_cycle(1, 1, 1, 1, 0);
    check("post_rst_owner", owner, 2'b01);

    // Randomized traffic.
    c0 = 0; c1 = 0; ack_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) ack_pct = (i / 200 % 4 == 0) ? 0 : (i / 200 % 4) * 33 + 1;
      if ($urandom_range(0, 29) == 0) c0 = ~c0;
      if ($urandom_range(0, 29) == 0) c1 = ~c1;
      run_cycle(c0, c0 && ($urandom_range(0, 3) != 0), c1, c1 && ($urandom_range(0, 3) != 0),
                $urandom_range(0, 99) < ack_pct);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
